// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control path.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] SRCA_RN     = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   typedef struct packed {
      logic       memreq;
      logic       irwrite;
      logic       adrsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic [1:0] immsrc;
      logic [1:0] regsrc;
      logic       aluop;
      logic       bytemem;
      logic       pcwrite;
      logic       regwrite;
      logic       memwrite;
   } ctrl_t;

   function automatic logic is_cmp(input logic [5:0] funct);
      return funct[4:1] == CMD_CMP;
   endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM and the multicycle datapath.
interface multicycle_main_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       CondEx;
   logic       MemReady;
   logic       MemReq;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       ALUOp;
   logic       ByteMem;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       MemErr;

   modport master (
      input  Op, Funct, Rd, CondEx, MemReady,
      output MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
      output ResultSrc, ImmSrc, RegSrc, ALUOp, ByteMem,
      output PCWrite, RegWrite, MemWrite, MemErr
   );

   modport slave (
      output Op, Funct, Rd, CondEx, MemReady,
      input  MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
      input  ResultSrc, ImmSrc, RegSrc, ALUOp, ByteMem,
      input  PCWrite, RegWrite, MemWrite, MemErr
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; flags a sticky error after WAIT_MAX.
module mem_wait_timer #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic timeout,
   output logic mem_err
);

   localparam int W = $clog2(WAIT_MAX + 1);

   logic [W-1:0] cnt;

   // the stalled cycle that would make the count reach WAIT_MAX
   assign timeout = inc && (cnt == W'(WAIT_MAX - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         if (timeout)
            mem_err <= 1'b1;
         if (clr)
            cnt <= '0;
         else if (inc)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM for the multicycle ARM datapath.
module multicycle_main_fsm
   import arm_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16
) (
   input logic                 clk,
   input logic                 reset,
   multicycle_main_fsm_if.master ctrl
);

   state_t state, state_n;
   ctrl_t  c;
   logic   timeout, mem_err, inc, clr, wb_pc;

   assign wb_pc = ctrl.Rd == 4'd15;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= state_n;
   end

   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.memreq    = 1'b1;
            c.alusrca   = SRCA_PC;
            c.alusrcb   = SRCB_FOUR;
            c.resultsrc = RES_ALURESULT;
            c.irwrite   = ctrl.MemReady;
            c.pcwrite   = ctrl.MemReady;
         end
         S_DECODE: begin
            c.alusrca   = SRCA_PC;
            c.alusrcb   = SRCB_FOUR;
            c.resultsrc = RES_ALURESULT;
         end
         S_MEMADR: begin
            c.alusrca = SRCA_RN;
            c.alusrcb = SRCB_IMM;
            c.immsrc  = IMM_12;
         end
         S_MEMREAD: begin
            c.memreq  = 1'b1;
            c.adrsrc  = 1'b1;
            c.bytemem = ctrl.Funct[2];
         end
         S_MEMWRITE: begin
            c.memreq   = ctrl.CondEx;
            c.memwrite = ctrl.CondEx;
            c.adrsrc   = 1'b1;
            c.regsrc   = 2'b10;
            c.bytemem  = ctrl.Funct[2];
         end
         S_MEMWB, S_ALUWB: begin
            c.resultsrc = (state == S_MEMWB) ? RES_DATA : RES_ALUOUT;
            c.pcwrite   = ctrl.CondEx & wb_pc;
            c.regwrite  = ctrl.CondEx & ~wb_pc;
         end
         S_EXECUTER: begin
            c.alusrca = SRCA_RN;
            c.alusrcb = SRCB_RD2;
            c.aluop   = 1'b1;
         end
         S_EXECUTEI: begin
            c.alusrca = SRCA_RN;
            c.alusrcb = SRCB_IMM;
            c.immsrc  = IMM_8;
            c.aluop   = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca   = SRCA_ALUOUT;
            c.alusrcb   = SRCB_IMM;
            c.immsrc    = IMM_24;
            c.resultsrc = RES_ALURESULT;
            c.pcwrite   = ctrl.CondEx;
         end
         default: c = '0;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         S_FETCH:
            if (ctrl.MemReady) state_n = S_DECODE;
         S_DECODE:
            unique case (1'b1)
               ctrl.Op == OP_MEM: state_n = S_MEMADR;
               ctrl.Op == OP_BR:  state_n = S_BRANCH;
               ctrl.Op == OP_DP && ctrl.Funct[5]:
                  state_n = S_EXECUTEI;
               ctrl.Op == OP_DP && !ctrl.Funct[5]:
                  state_n = S_EXECUTER;
               default: state_n = S_FETCH;
            endcase
         S_MEMADR:
            state_n = ctrl.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:
            if (ctrl.MemReady) state_n = S_MEMWB;
         S_MEMWRITE:
            if (!ctrl.CondEx || ctrl.MemReady) state_n = S_FETCH;
         S_EXECUTER, S_EXECUTEI:
            state_n = is_cmp(ctrl.Funct) ? S_FETCH : S_ALUWB;
         default:
            state_n = S_FETCH;
      endcase
      // a stalled access that runs out of time abandons the instruction
      if (timeout) state_n = S_FETCH;
   end

   assign inc = c.memreq & ~ctrl.MemReady;
   assign clr = (state_n != state) | timeout;

   mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc     (inc),
      .timeout (timeout),
      .mem_err (mem_err)
   );

   assign ctrl.MemReq    = c.memreq;
   assign ctrl.IRWrite   = c.irwrite;
   assign ctrl.AdrSrc    = c.adrsrc;
   assign ctrl.ALUSrcA   = c.alusrca;
   assign ctrl.ALUSrcB   = c.alusrcb;
   assign ctrl.ResultSrc = c.resultsrc;
   assign ctrl.ImmSrc    = c.immsrc;
   assign ctrl.RegSrc    = c.regsrc;
   assign ctrl.ALUOp     = c.aluop;
   assign ctrl.ByteMem   = c.bytemem;
   assign ctrl.PCWrite   = c.pcwrite;
   assign ctrl.RegWrite  = c.regwrite;
   assign ctrl.MemWrite  = c.memwrite;
   assign ctrl.MemErr    = mem_err;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: table-driven instructions, corner
// sequences and a randomized run against a phase-level reference model.
module tb_multicycle_main_fsm;

   localparam int WAIT_MAX = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   multicycle_main_fsm_if bus ();

   multicycle_main_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   typedef struct packed {
      logic       memreq;
      logic       irwrite;
      logic       adrsrc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] res;
      logic [1:0] imm;
      logic [1:0] regsrc;
      logic       aluop;
      logic       bytemem;
      logic       pcwrite;
      logic       regwrite;
      logic       memwrite;
      logic       memerr;
   } o_t;

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic       ce;
      int         delay;
      int         cyc;
      int         rw;
      int         pcw;
      int         mw;
      int         bm;
   } vec_t;

   int errors = 0;
   int checks = 0;

   string ph = "FETCH";
   int    waits = 0;
   bit    err = 1'b0;

   function automatic o_t model_out();
      o_t e;
      logic wb;
      e = '0;
      e.memerr = err;
      wb = bus.CondEx;
      case (ph)
         "FETCH": begin
            e.memreq = 1'b1;
            e.srca = 2'd1; e.srcb = 2'd2; e.res = 2'd2;
            e.irwrite = bus.MemReady;
            e.pcwrite = bus.MemReady;
         end
         "DECODE": begin
            e.srca = 2'd1; e.srcb = 2'd2; e.res = 2'd2;
         end
         "MEMADR": begin
            e.srcb = 2'd1; e.imm = 2'd1;
         end
         "MEMREAD": begin
            e.memreq = 1'b1; e.adrsrc = 1'b1;
            e.bytemem = bus.Funct[2];
         end
         "MEMWRITE": begin
            e.memreq = bus.CondEx; e.memwrite = bus.CondEx;
            e.adrsrc = 1'b1; e.regsrc = 2'd2;
            e.bytemem = bus.Funct[2];
         end
         "MEMWB", "ALUWB": begin
            e.res = (ph == "MEMWB") ? 2'd1 : 2'd0;
            if (bus.Rd == 4'd15) e.pcwrite = wb;
            else e.regwrite = wb;
         end
         "EXECUTER": e.aluop = 1'b1;
         "EXECUTEI": begin
            e.aluop = 1'b1; e.srcb = 2'd1;
         end
         "BRANCH": begin
            e.srca = 2'd2; e.srcb = 2'd1; e.imm = 2'd2;
            e.res = 2'd2; e.pcwrite = bus.CondEx;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic o_t dut_out();
      o_t d;
      d.memreq = bus.MemReq;     d.irwrite = bus.IRWrite;
      d.adrsrc = bus.AdrSrc;     d.srca = bus.ALUSrcA;
      d.srcb = bus.ALUSrcB;      d.res = bus.ResultSrc;
      d.imm = bus.ImmSrc;        d.regsrc = bus.RegSrc;
      d.aluop = bus.ALUOp;       d.bytemem = bus.ByteMem;
      d.pcwrite = bus.PCWrite;   d.regwrite = bus.RegWrite;
      d.memwrite = bus.MemWrite; d.memerr = bus.MemErr;
      return d;
   endfunction

   task automatic model_advance();
      string nx;
      o_t e;
      nx = ph;
      e = model_out();
      case (ph)
         "FETCH":    if (bus.MemReady) nx = "DECODE";
         "DECODE":
            case (bus.Op)
               2'd0: nx = bus.Funct[5] ? "EXECUTEI" : "EXECUTER";
               2'd1: nx = "MEMADR";
               2'd2: nx = "BRANCH";
               default: nx = "FETCH";
            endcase
         "MEMADR":   nx = bus.Funct[0] ? "MEMREAD" : "MEMWRITE";
         "MEMREAD":  if (bus.MemReady) nx = "MEMWB";
         "MEMWRITE": if (!bus.CondEx || bus.MemReady) nx = "FETCH";
         "EXECUTER", "EXECUTEI":
            nx = (bus.Funct[4:1] == 4'b1010) ? "FETCH" : "ALUWB";
         default:    nx = "FETCH";
      endcase
      if (e.memreq && !bus.MemReady) begin
         waits++;
         if (waits >= WAIT_MAX) begin
            err = 1'b1;
            nx = "FETCH";
            waits = 0;
         end
      end
      if (nx != ph) waits = 0;
      ph = nx;
   endtask

   task automatic chk(input string n, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", n, got, want);
      end
   endtask

   // inputs are driven at the negedge before calling
   task automatic cycle(output o_t d);
      o_t e;
      #1;
      e = model_out();
      d = dut_out();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL cycle t=%0t ph=%s got=%h want=%h",
                  $time, ph, d, e);
      end
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.MemReady = 1'b0;
      @(posedge clk);
      ph = "FETCH"; waits = 0; err = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_instr(input vec_t v);
      int n, rw, pcw, mw, bm, w;
      o_t d;
      bit at_fetch;
      n = 0; rw = 0; pcw = 0; mw = 0; bm = 0; w = 0;
      bus.Op = v.op; bus.Funct = v.funct; bus.Rd = v.rd;
      do begin
         bus.CondEx = v.ce;
         if (ph == "MEMREAD" || ph == "MEMWRITE") begin
            bus.MemReady = (w >= v.delay);
            w++;
         end else begin
            bus.MemReady = 1'b1;
         end
         cycle(d);
         n++;
         rw += int'(d.regwrite);
         pcw += int'(d.pcwrite);
         mw += int'(d.memwrite);
         bm += int'(d.bytemem);
         at_fetch = bus.MemReq && !bus.AdrSrc;
      end while (!at_fetch && n < 40);
      chk({v.name, "_cycles"}, n, v.cyc);
      chk({v.name, "_regwrite"}, rw, v.rw);
      chk({v.name, "_pcwrite"}, pcw, v.pcw);
      chk({v.name, "_memwrite"}, mw, v.mw);
      chk({v.name, "_bytemem"}, bm, v.bm);
   endtask

   vec_t tbl [13];
   vec_t tmo;

   initial begin
      o_t d;
      bus.Op = 2'd0; bus.Funct = 6'd0; bus.Rd = 4'd0;
      bus.CondEx = 1'b0; bus.MemReady = 1'b0;
      reset = 1'b1;

      tbl[0]  = '{"addi",    2'd0, 6'b101000, 4'd1,  1'b1, 0, 4, 1, 1, 0, 0};
      tbl[1]  = '{"ldrb",    2'd1, 6'b011101, 4'd2,  1'b1, 3, 8, 1, 1, 0, 4};
      tbl[2]  = '{"str_nc",  2'd1, 6'b011000, 4'd3,  1'b0, 0, 4, 0, 1, 0, 0};
      tbl[3]  = '{"str_wt",  2'd1, 6'b011000, 4'd3,  1'b1, 2, 6, 0, 1, 3, 0};
      tbl[4]  = '{"strb",    2'd1, 6'b011100, 4'd3,  1'b1, 0, 4, 0, 1, 1, 1};
      tbl[5]  = '{"cmp",     2'd0, 6'b010101, 4'd0,  1'b1, 0, 3, 0, 1, 0, 0};
      tbl[6]  = '{"b_taken", 2'd2, 6'b100000, 4'd0,  1'b1, 0, 3, 0, 2, 0, 0};
      tbl[7]  = '{"b_not",   2'd2, 6'b100000, 4'd0,  1'b0, 0, 3, 0, 1, 0, 0};
      tbl[8]  = '{"add_pc",  2'd0, 6'b001000, 4'd15, 1'b1, 0, 4, 0, 2, 0, 0};
      tbl[9]  = '{"op11",    2'd3, 6'b000000, 4'd0,  1'b1, 0, 2, 0, 1, 0, 0};
      tbl[10] = '{"ldr_pc",  2'd1, 6'b011001, 4'd15, 1'b1, 0, 5, 0, 2, 0, 0};
      tbl[11] = '{"add_nc",  2'd0, 6'b101000, 4'd4,  1'b0, 0, 4, 0, 1, 0, 0};
      tbl[12] = '{"ldr_nc",  2'd1, 6'b011001, 4'd5,  1'b0, 1, 6, 0, 1, 0, 0};

      @(negedge clk);
      do_reset();
      #1;
      chk("reset_memreq", int'(bus.MemReq), 1);
      chk("reset_adrsrc", int'(bus.AdrSrc), 0);
      chk("reset_irwrite", int'(bus.IRWrite), 0);
      chk("reset_memerr", int'(bus.MemErr), 0);
      @(negedge clk);

      for (int i = 0; i < 13; i++) run_instr(tbl[i]);

      // fetch stall timing out
      do_reset();
      bus.Op = 2'd0; bus.CondEx = 1'b1;
      for (int i = 0; i < WAIT_MAX - 1; i++) begin
         bus.MemReady = 1'b0;
         cycle(d);
      end
      chk("tmo_memerr_early", int'(bus.MemErr), 0);
      bus.MemReady = 1'b0;
      cycle(d);
      chk("tmo_memerr_set", int'(bus.MemErr), 1);
      chk("tmo_in_fetch", int'(bus.MemReq && !bus.AdrSrc), 1);
      for (int i = 0; i < 4; i++) begin
         bus.MemReady = 1'b0;
         cycle(d);
      end
      chk("tmo_sticky", int'(bus.MemErr), 1);
      do_reset();
      chk("tmo_reset_clr", int'(bus.MemErr), 0);

      // reset in the middle of a stalled store
      bus.Op = 2'd1; bus.Funct = 6'b011000; bus.Rd = 4'd1;
      bus.CondEx = 1'b1;
      for (int i = 0; i < 10 && ph != "MEMWRITE"; i++) begin
         bus.MemReady = (ph == "FETCH");
         cycle(d);
      end
      bus.MemReady = 1'b0;
      cycle(d);
      #1;
      chk("str_memwrite_held", int'(bus.MemWrite), 1);
      do_reset();
      chk("rst_memwrite_drop", int'(bus.MemWrite), 0);
      chk("rst_back_fetch", int'(bus.MemReq && !bus.AdrSrc), 1);

      // load that never completes
      tmo = '{"ldr_tmo", 2'd1, 6'b011001, 4'd6, 1'b1, 100, 19, 0, 1, 0, 0};
      run_instr(tmo);
      chk("ldr_tmo_memerr", int'(bus.MemErr), 1);

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            if (ph == "FETCH") begin
               bus.Op = 2'($urandom_range(0, 3));
               bus.Funct = 6'($urandom);
               bus.Rd = ($urandom_range(0, 3) == 0) ? 4'd15
                                                    : 4'($urandom);
            end
            bus.CondEx = ($urandom_range(0, 3) != 0);
            bus.MemReady = ($urandom_range(0, 2) != 0);
            cycle(d);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
